// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry circular FIFO with valid/ready on both sides.
// Optional macro IFQ_STALL_CNT_EN adds a saturating fetch-stall counter output.
module fetch_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_valid,
    input  logic [15:0] f_instr,
    input  logic [15:0] f_pc,
    input  logic [15:0] f_pcPlusTwo,
    output logic        f_ready,
    output logic        d_valid,
    output logic [15:0] d_instr,
    output logic [15:0] d_pc,
    output logic [15:0] d_pcPlusTwo,
    input  logic        d_ready,
    input  logic        flush
`ifdef IFQ_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [15:0] mem_instr      [DEPTH];
    logic [15:0] mem_pc         [DEPTH];
    logic [15:0] mem_pcPlusTwo  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             enq;
    logic             deq;

    assign f_ready = (count != FULL_CNT);
    assign d_valid = (count != '0);
    assign enq     = f_valid & f_ready & ~flush;
    assign deq     = d_valid & d_ready & ~flush;

    // Storage is deliberately left out of reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_instr[wr_ptr]     <= f_instr;
            mem_pc[wr_ptr]        <= f_pc;
            mem_pcPlusTwo[wr_ptr] <= f_pcPlusTwo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (enq && !deq) begin
                count <= count + CNT_ONE;
            end else if (deq && !enq) begin
                count <= count - CNT_ONE;
            end
        end
    end

    always_comb begin
        d_instr     = NOP_INSTR;
        d_pc        = 16'h0000;
        d_pcPlusTwo = 16'h0000;
        if (d_valid) begin
            d_instr     = mem_instr[rd_ptr];
            d_pc        = mem_pc[rd_ptr];
            d_pcPlusTwo = mem_pcPlusTwo[rd_ptr];
        end
    end

`ifdef IFQ_STALL_CNT_EN
    // Counts cycles where fetch is held off by a full queue; survives flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'h0000;
        end else if (f_valid && !f_ready && !flush && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`endif

endmodule
